// File: rtl/debounce_ctrl.sv
// ---------------------------------------------------------------------------
// debounce_ctrl
//   Debounce controller for one raw push-button or switch input. The raw
//   input passes through a two-flop synchroniser. A four-state FSM with a
//   qualification counter then accepts a level change only after it has been
//   stable for DB_CYCLES enabled cycles. The block produces a clean level
//   plus registered one-cycle press (and optionally release) strobes.
//
// Configuration macro:
//   REL_PULSE_EN  when defined, adds the rel_pulse output and its logic.
//                 When undefined, that port is absent and a release still
//                 clears db_out.
//
// Parameters:
//   DB_CYCLES     stable cycles needed to accept a level change (>= 2)
//   CW            counter width; 2**CW must be >= DB_CYCLES
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous, active-low reset
//   en            1 = FSM/counter advance, 0 = hold (synchroniser still runs)
//   din           raw asynchronous input
//   db_out        debounced level
//   press_pulse   one-cycle strobe on an accepted 0->1 change
//   rel_pulse     one-cycle strobe on an accepted 1->0 change (REL_PULSE_EN)
//   state_o       current FSM state: LOW=00 CHK_HI=01 HIGH=10 CHK_LO=11
// ---------------------------------------------------------------------------
module debounce_ctrl #(
    parameter int DB_CYCLES = 500000,
    parameter int CW        = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       din,
    output logic       db_out,
    output logic       press_pulse,
`ifdef REL_PULSE_EN
    output logic       rel_pulse,
`endif
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        LOW    = 2'b00,
        CHK_HI = 2'b01,
        HIGH   = 2'b10,
        CHK_LO = 2'b11
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          s1_q;
    logic          s2_q;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          cntLast;
    logic          dbOut_q;
    logic          press_q;
`ifdef REL_PULSE_EN
    logic          rel_q;
`endif

    // Two-flop synchroniser. It runs on every edge, even when en is low, so
    // the FSM sees a fresh and settled sample as soon as it resumes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= din;
            s2_q <= s1_q;
        end
    end

    assign cnt_d   = cnt_q + CW'(1);
    assign cntLast = (cnt_q == CNT_LAST);

    // The qualification FSM keeps all of its outputs registered. The counter
    // restarts from zero on every entry into a check state. The counter only
    // counts up while the synchronised level stays at the candidate value,
    // so it stops at DB_CYCLES-1 and never wraps. The strobes default to low
    // on every edge, which makes each one last exactly one cycle. When en is
    // low, the state, counter and level are frozen and the strobes are held
    // low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LOW;
            cnt_q   <= '0;
            dbOut_q <= 1'b0;
            press_q <= 1'b0;
`ifdef REL_PULSE_EN
            rel_q   <= 1'b0;
`endif
        end else begin
            press_q <= 1'b0;
`ifdef REL_PULSE_EN
            rel_q   <= 1'b0;
`endif
            if (en) begin
                case (state_q)
                    LOW: begin
                        if (s2_q) begin
                            state_q <= CHK_HI;
                            cnt_q   <= '0;
                        end
                    end
                    CHK_HI: begin
                        if (!s2_q) begin
                            state_q <= LOW;
                            cnt_q   <= '0;
                        end else if (cntLast) begin
                            state_q <= HIGH;
                            dbOut_q <= 1'b1;
                            press_q <= 1'b1;
                        end else begin
                            cnt_q   <= cnt_d;
                        end
                    end
                    HIGH: begin
                        if (!s2_q) begin
                            state_q <= CHK_LO;
                            cnt_q   <= '0;
                        end
                    end
                    CHK_LO: begin
                        if (s2_q) begin
                            state_q <= HIGH;
                            cnt_q   <= '0;
                        end else if (cntLast) begin
                            state_q <= LOW;
                            dbOut_q <= 1'b0;
`ifdef REL_PULSE_EN
                            rel_q   <= 1'b1;
`endif
                        end else begin
                            cnt_q   <= cnt_d;
                        end
                    end
                endcase
            end
        end
    end

    assign db_out      = dbOut_q;
    assign press_pulse = press_q;
`ifdef REL_PULSE_EN
    assign rel_pulse   = rel_q;
`endif
    assign state_o     = state_q;

endmodule

// File: tb/tb_debounce_ctrl.sv
module tb_debounce_ctrl;

    logic       clk;
    logic       rst;
    logic       en;
    logic       din;
    logic       dbOut;
    logic       pressPulse;
`ifdef REL_PULSE_EN
    logic       relPulse;
`endif
    logic [1:0] stateO;

    int testsRun    = 0;
    int testsFailed = 0;

    debounce_ctrl #(
        .DB_CYCLES(4),
        .CW       (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .din        (din),
        .db_out     (dbOut),
        .press_pulse(pressPulse),
`ifdef REL_PULSE_EN
        .rel_pulse  (relPulse),
`endif
        .state_o    (stateO)
    );

    // Free-running clock: 10 time-unit period, rising edges at 5, 15, 25...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive all inputs together with blocking assignments.
    task automatic applyStimulus(input logic dinVal, input logic enVal, input logic rstVal);
        din = dinVal;
        en  = enVal;
        rst = rstVal;
    endtask

    // Advance n rising edges, then settle 1 unit past the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [1:0] observed, input logic [1:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Check the debounced level, the press strobe and the state in one call.
    task automatic checkLevels(input string tag, input logic expDb, input logic expPress, input logic [1:0] expState);
        checkOutput({tag, ".db_out"}, {1'b0, dbOut}, {1'b0, expDb});
        checkOutput({tag, ".press"}, {1'b0, pressPulse}, {1'b0, expPress});
        checkOutput({tag, ".state"}, stateO, expState);
    endtask

    task automatic checkRel(input string tag, input logic expRel);
`ifdef REL_PULSE_EN
        checkOutput({tag, ".rel"}, {1'b0, relPulse}, {1'b0, expRel});
`else
        if (expRel === 1'b1 || expRel === 1'b0) begin
            // The release strobe port does not exist in this build.
        end
`endif
    endtask

    initial begin
        // Reset is asserted with din high. Outputs must be clean before any edge.
        applyStimulus(1'b1, 1'b1, 1'b0);
        #2;
        checkLevels("rst_async_t0", 1'b0, 1'b0, 2'b00);
        tick(2);
        checkLevels("rst_held", 1'b0, 1'b0, 2'b00);

        // Release reset with din low. The FSM must stay in LOW.
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick(3);
        checkLevels("idle_low", 1'b0, 1'b0, 2'b00);

        // Clean press: edge 3 enters CHK_HI, and edge 7 accepts the new level.
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick(2);
        checkLevels("press_e2", 1'b0, 1'b0, 2'b00);
        tick(1);
        checkLevels("press_e3", 1'b0, 1'b0, 2'b01);
        tick(3);
        checkLevels("press_e6", 1'b0, 1'b0, 2'b01);
        tick(1);
        checkLevels("press_e7", 1'b1, 1'b1, 2'b10);
        tick(1);
        checkLevels("press_e8", 1'b1, 1'b0, 2'b10);

        // Release from HIGH: edge 3 enters CHK_LO, and edge 7 drops the level.
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick(2);
        checkLevels("rel_e2", 1'b1, 1'b0, 2'b10);
        tick(1);
        checkLevels("rel_e3", 1'b1, 1'b0, 2'b11);
        tick(3);
        checkLevels("rel_e6", 1'b1, 1'b0, 2'b11);
        checkRel("rel_e6", 1'b0);
        tick(1);
        checkLevels("rel_e7", 1'b0, 1'b0, 2'b00);
        checkRel("rel_e7", 1'b1);
        tick(1);
        checkRel("rel_e8", 1'b0);

        // Bounce: din is high for only 3 edges. The FSM peaks at count 2 and
        // then returns to LOW at edge 6.
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick(3);
        checkLevels("bounce_e3", 1'b0, 1'b0, 2'b01);
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick(2);
        checkLevels("bounce_e5", 1'b0, 1'b0, 2'b01);
        tick(1);
        checkLevels("bounce_e6", 1'b0, 1'b0, 2'b00);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            checkLevels($sformatf("bounce_after%0d", i), 1'b0, 1'b0, 2'b00);
        end

        // Hold: en drops after edge 4 (CHK_HI, count 1) for 5 edges.
        // The level is accepted at edge 12 instead of edge 7.
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick(4);
        checkLevels("hold_e4", 1'b0, 1'b0, 2'b01);
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int i = 5; i <= 9; i++) begin
            tick(1);
            checkLevels($sformatf("hold_frozen_e%0d", i), 1'b0, 1'b0, 2'b01);
        end
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick(2);
        checkLevels("hold_e11", 1'b0, 1'b0, 2'b01);
        tick(1);
        checkLevels("hold_e12", 1'b1, 1'b1, 2'b10);

        // en is low while the strobe is high. The strobe must still clear,
        // and the state must not move even though din has gone low.
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick(4);
        checkLevels("hold_high_frozen", 1'b1, 1'b0, 2'b10);

        // Resume and return to LOW. The synchroniser already holds the low
        // level, so CHK_LO is entered on the first enabled edge and LOW on
        // the fifth.
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick(1);
        checkLevels("resume_e1", 1'b1, 1'b0, 2'b11);
        tick(4);
        checkLevels("resume_e5", 1'b0, 1'b0, 2'b00);
        checkRel("resume_e5", 1'b1);

        // Reset in mid-check: count reaches 2 after edge 5. Reset is asserted
        // mid-cycle and must clear the state immediately.
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick(5);
        checkLevels("midchk_e5", 1'b0, 1'b0, 2'b01);
        #3;
        applyStimulus(1'b1, 1'b1, 1'b0);
        #1;
        checkLevels("midchk_rst", 1'b0, 1'b0, 2'b00);
        tick(1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick(6);
        checkLevels("postrst_e6", 1'b0, 1'b0, 2'b01);
        tick(1);
        checkLevels("postrst_e7", 1'b1, 1'b1, 2'b10);

        // Async reset asserted mid-cycle while HIGH clears db_out at once.
        #3;
        applyStimulus(1'b1, 1'b1, 1'b0);
        #1;
        checkLevels("rst_from_high", 1'b0, 1'b0, 2'b00);
        checkRel("rst_from_high", 1'b0);
        tick(2);
        checkLevels("rst_from_high_held", 1'b0, 1'b0, 2'b00);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
